instruction_fetch_unit: RTL and testbench

- Front end of the pipelined RV32I core.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned words with their PCs and presents them as the IF/ID register to the decode stage, where the immediate generator consumes `if_id_inst`.
- Handles back-pressure from decode and flushes on control-flow redirects from EX.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RV32I front-end definitions.
// Opcodes, NOP encoding, fetch step and IF/ID bundle.
package instruction_fetch_unit_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO used for the IF/ID buffer and PC queue.
// Ports: push/din, pop, flush, count, head (oldest entry).
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC, imem requests, IF/ID buffer.
// Ports: imem_* request/response, redirect_*, stall, if_id_*.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] pcq_count;
  logic [31:0]   pcq_head;
  logic          run;
  if_id_t        head;
  if_id_t        entry;
  logic          accept;
  logic          ret;
  logic          killing;
  logic          live;
  logic          pop;
  logic          unused;

  assign unused = ^redirect_pc[1:0];

  // Credit counts buffered words plus every in-flight
  // request, killed ones included, so the buffer never
  // overflows when a response lands.
  assign imem_req = run && !redirect_valid &&
    ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH));
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  assign ret     = imem_rvalid && (outstanding != '0);
  assign killing = ret && (kill_cnt != '0);
  assign live    = ret && (kill_cnt == '0) &&
                   (pcq_count != '0);

  assign entry = {pcq_head, imem_rdata};

  assign if_id_valid = (fifo_count != '0);
  assign if_id_pc    = if_id_valid ? head.pc : '0;
  assign if_id_inst  = if_id_valid ? head.inst : NOP_INST;
  assign pop = if_id_valid && !stall && !redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
      run         <= 1'b0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(ret);
      if (redirect_valid) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this edge is stale.
        kill_cnt <= outstanding - CW'(ret);
      end else begin
        if (accept)  pc       <= pc + INST_BYTES;
        if (killing) kill_cnt <= kill_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (live && !redirect_valid),
    .din    (entry),
    .pop    (pop),
    .flush  (redirect_valid),
    .count  (fifo_count),
    .head   (head)
  );

  // PCs of live in-flight requests; killed ones are
  // dropped from it at the redirect.
  fetch_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_pcq (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (accept),
    .din    (pc),
    .pop    (live),
    .flush  (redirect_valid),
    .count  (pcq_count),
    .head   (pcq_head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit.
// Memory model returns addr ^ KEY one cycle after accept.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;

  int          tests = 0;
  int          fails = 0;
  int          n_del = 0;
  int          n_acc = 0;
  logic [31:0] exp_pc;
  logic [63:0] exp_q [$];
  logic [31:0] mem_q [$];
  logic        mem_en;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_pc"}, if_id_pc, 32'h0);
    chk({tag, "_inst"}, if_id_inst, NOP_INST);
  endtask

  // One clock: inputs are set at the negedge by the caller.
  task automatic tick();
    logic [63:0] e;
    #1;
    if (if_id_valid && !stall && !redirect_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("if_id_pc", if_id_pc, e[63:32]);
        chk("if_id_inst", if_id_inst, e[31:0]);
      end
      n_del++;
    end
    if (imem_req && imem_ready) begin
      chk("imem_addr", imem_addr, exp_pc);
      exp_q.push_back({exp_pc, exp_pc ^ KEY});
      mem_q.push_back(imem_addr);
      exp_pc += 32'd4;
      n_acc++;
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    if (mem_en && mem_q.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q.pop_front() ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    int   a0;
    logic found;
    reset_n        = 1'b0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    mem_en         = 1'b1;
    exp_pc         = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset("rst");

    // Release and stream.
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    d0 = n_del;
    repeat (11) tick();
    chk("stream_progress", 32'(n_del - d0 >= 5), 32'd1);

    // Stall with a full buffer.
    stall = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      tick();
      if (s >= 3) begin
        chk("stall_valid", 32'(if_id_valid), 32'd1);
        if (exp_q.size() != 0) begin
          chk("stall_pc", if_id_pc, exp_q[0][63:32]);
          chk("stall_inst", if_id_inst, exp_q[0][31:0]);
        end
      end
      if (s >= 4) chk("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    repeat (8) tick();

    // Redirect with two requests in flight.
    mem_en = 1'b0;
    repeat (4) tick();
    chk("inflight_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    mem_en         = 1'b1;
    chk("redir_flush", 32'(if_id_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (if_id_valid) found = 1'b1;
      else tick();
    end
    chk("redir_budget", 32'(found), 32'd1);
    chk("redir_first_pc", if_id_pc, 32'h0000_0100);
    repeat (4) tick();

    // Redirect + rvalid + stall in one cycle.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_rvalid && if_id_valid) found = 1'b1;
      else tick();
    end
    chk("rv_budget", 32'(found), 32'd1);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    chk("rv_flush", 32'(if_id_valid), 32'd0);
    #1;
    chk("rv_req", 32'(imem_req), 32'd1);
    chk("rv_addr", imem_addr, 32'h0000_0200);
    repeat (6) tick();

    // Memory not ready at PC 0x10.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    imem_ready     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_hold_addr", imem_addr, 32'h0000_0010);
    end
    chk("rdy_hold_req", 32'(imem_req), 32'd1);
    a0 = n_acc;
    imem_ready = 1'b1;
    tick();
    chk("rdy_one_acc", 32'(n_acc - a0), 32'd1);
    chk("rdy_next_addr", imem_addr, 32'h0000_0014);
    repeat (6) tick();

    // Address wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    d0 = n_del;
    repeat (10) tick();
    chk("wrap_progress", 32'(n_del - d0 >= 3), 32'd1);

    // Asynchronous reset mid-stream.
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("arst");
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    mem_q.delete();
    exp_q.delete();
    exp_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = n_del;
    repeat (12) tick();
    chk("post_rst_progress", 32'(n_del - d0 >= 5), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
